fsm_seq_detect_param: RTL and testbench
=======================================

// Module: fsm_seq_detect_param
// PURPOSE
//  Parametrised serial pattern detector, successor to the fixed 4-bit Mealy detector.
//  - Runtime-loadable pattern of 1..PAT_W bits.
//  - Overlapping or non-overlapping match mode.
//  - Input valid qualifier, registered match pulse, saturating match counter.
//  - Sits after a serial bit source: framing/sync-word search in the training datapaths.
// PARAMETERS
//  PAT_W        4        max pattern length in bits (>=2)
//  CNT_W        8        match counter width
//  DEFAULT_PAT  4'b1011  pattern register reset value (PAT_W bits)
//  DEFAULT_LEN  4        pattern length reset value
//  LEN_W        $clog2(PAT_W+1)  derived localparam; width of pat_len
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  en          in   1      detector enable; 0 = OFF, history cleared
//  in_valid    in   1      in_bit is consumed on this edge
//  in_bit      in   1      serial data bit
//  overlap_en  in   1      1 = overlapping matches, 0 = history cleared after a match
//  pat_load    in   1      load pat_val/pat_len and flush history
//  pat_val     in   PAT_W  pattern; bit [pat_len-1] is the first bit received, bit 0 the last
//  pat_len     in   LEN_W  active length; 0 or >PAT_W = detection disabled
//  cnt_clr     in   1      synchronous clear of match_cnt
//  match       out  1      one-cycle pulse; registered
//  match_cnt   out  CNT_W  saturating count of matches
//  primed      out  1      1 when state==HUNT
// BEHAVIOUR
//  Reset values:
//  - state=OFF, hist=0, fill=0, match=0, match_cnt=0, primed=0.
//  - pattern register = DEFAULT_PAT, length register = DEFAULT_LEN.
//  FSM states:
//  - OFF:  en=0.
//  - FILL: en=1 and fill<len.
//  - HUNT: en=1 and fill>=len.
//  - Any state -> OFF when en=0; hist and fill are cleared.
//  - OFF -> FILL when en=1.
//  - FILL -> HUNT when fill reaches len.
//  - HUNT -> FILL after a non-overlap match or a pat_load.
//  Accepted bit (en & in_valid & ~pat_load):
//  - hist <= {hist[PAT_W-2:0], in_bit}.
//  - fill <= min(fill+1, PAT_W).
//  Match condition, evaluated on the next history value including the current bit:
//  - (fill_next>=len) & ((hist_next ^ pat) & mask(len)) == 0.
//  - mask = low len bits set.
//  - Reached state at the edge is HUNT; FILL if a non-overlap match clears fill.
//  On a match, at the accepting edge:
//  - match<=1 for exactly one cycle (latency 1 clock from the bit's sampling edge).
//  - match_cnt increments, holding at all-ones (no wrap).
//  - overlap_en=0: hist and fill are cleared at the same edge.
//  - overlap_en=1: hist is kept, so the next match may reuse trailing bits.
//  No accepted bit, or en=0: match<=0 and all state holds, except the en=0 clear above.
//  pat_load:
//  - Registers pat_val/pat_len; hist=0, fill=0.
//  - A bit presented on the same edge is discarded.
//  - match<=0.
//  - match_cnt is unaffected.
//  pat_len invalid (0 or >PAT_W): never matches, primed=0, state stays FILL.
//  cnt_clr:
//  - Same edge as a match gives match_cnt=1; cnt_clr alone gives 0.
//  - match still pulses.
//  Reset mid-stream: everything returns to reset values asynchronously; the pattern reverts to the default.
//  Synchronous to clk only; no combinational path from inputs to outputs.
// STRUCTURE
//  Package seq_detect_pkg:
//  - State localparams OFF=2'd0, FILL=2'd1, HUNT=2'd2.
//  - clog2 helper function.
//  Sub-module sat_counter #(W): inc, clr, count, saturating; instantiated for match_cnt.
//  Pattern/length registers, history shifter, fill counter and FSM stay in the top level.
// TESTING
//  1. Reset, en=1, valid every cycle, bits 1,0,1,1,0,1,1, overlap_en=0, default pattern
//     -> match pulses only after bit 4 (cycle after its edge); match_cnt=1.
//  2. Same stream, overlap_en=1 -> match after bit 4 and after bit 7; match_cnt=2.
//  3. pat_load pat_val=3'b110 (PAT_W=4 build, pat_len=3), stream 1,1,0,1,1,0 with gaps in_valid=0
//     -> match after bits 3 and 6 only; bits during gaps are ignored; primed low until 3 bits received.
//  4. CNT_W=2, overlap_en=1, pattern 1 (pat_len=1), eight 1s -> match_cnt 1,2,3,3,3...;
//     cnt_clr with a match -> 1.
//  5. Assert rst after bits 1,0,1 of 1011 and complete the stream -> no match.
//     en toggled low mid-pattern -> history cleared, no match.
//  6. pat_len=0 with any stream -> match never asserts, primed=0.
//     pat_load on the same edge as an in_valid bit -> that bit is not counted in fill.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HUNT = 2'd2;

  typedef enum logic [1:0] {
    StOff  = OFF,
    StFill = FILL,
    StHunt = HUNT
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an increment yields 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fsm_seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern of 1..PAT_W bits, overlap control,
// registered match pulse and saturating match counter.
module fsm_seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011),
  parameter int unsigned      DEFAULT_LEN = 4,
  localparam int unsigned     LEN_W       = clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_val,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             primed
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  // The oldest bit is never needed after the shift, so only PAT_W-1 bits are stored.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  state_e           state_q, state_d;
  logic             match_q, match_d;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill_nxt;
  logic             len_ok;
  logic             len_ok_d;
  logic             accept;
  logic             hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign len_ok   = (len_q != '0) && (len_q <= LEN_W'(PAT_W));
  assign accept   = en & in_valid & ~pat_load;
  assign hist_nxt = {hist_q, in_bit};
  assign fill_nxt = (fill_q >= LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
  assign hit      = accept & len_ok & (fill_nxt >= len_q) &
                    (((hist_nxt ^ pat_q) & mask) == '0);

  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    state_d  = state_q;
    len_ok_d = 1'b0;

    if (pat_load) begin
      pat_d = pat_val;
      len_d = pat_len;
    end

    if (!en || pat_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      match_d = hit;
      if (hit && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_nxt[PAT_W-2:0];
        fill_d = fill_nxt;
      end
    end

    // State follows directly from the post-edge enable, fill and length.
    len_ok_d = (len_d != '0) && (len_d <= LEN_W'(PAT_W));
    if (!en) begin
      state_d = StOff;
    end else if (len_ok_d && (fill_d >= len_d)) begin
      state_d = StHunt;
    end else begin
      state_d = StFill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= DEFAULT_PAT;
      len_q   <= LEN_W'(DEFAULT_LEN);
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= StOff;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (match_d),
    .clr  (cnt_clr),
    .count(match_cnt)
  );

  assign match  = match_q;
  assign primed = (state_q == StHunt);

endmodule

// File: tb/tb_fsm_seq_detect_param.sv
// Bench for fsm_seq_detect_param: queue-based reference model checked every cycle plus
// directed vectors with literal expectations.
module tb_fsm_seq_detect_param;

  localparam int unsigned PAT_W   = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       overlap_en = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_val = '0;
  logic [2:0] pat_len = '0;
  logic       cnt_clr = 1'b0;
  logic       match;
  logic [1:0] match_cnt;
  logic       primed;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_seq_detect_param #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .overlap_en(overlap_en),
    .pat_load  (pat_load),
    .pat_val   (pat_val),
    .pat_len   (pat_len),
    .cnt_clr   (cnt_clr),
    .match     (match),
    .match_cnt (match_cnt),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the accepted bit stream since the last flush, capped at PAT_W bits.
  bit         m_hist[$];
  logic [3:0] m_pat;
  int         m_len;
  int         m_cnt;
  logic       m_match;
  logic       m_primed;

  function automatic bit len_ok(input int l);
    return (l >= 1) && (l <= int'(PAT_W));
  endfunction

  always @(posedge clk or posedge rst) begin
    bit hit;
    if (rst) begin
      m_hist.delete();
      m_pat    = 4'b1011;
      m_len    = 4;
      m_cnt    = 0;
      m_match  = 1'b0;
      m_primed = 1'b0;
    end else begin
      hit = 1'b0;
      if (pat_load) begin
        m_pat = pat_val;
        m_len = int'(pat_len);
      end
      if (!en || pat_load) begin
        m_hist.delete();
      end else if (in_valid) begin
        m_hist.push_back(in_bit);
        if (m_hist.size() > int'(PAT_W)) void'(m_hist.pop_front());
        if (len_ok(m_len) && (m_hist.size() >= m_len)) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++) begin
            if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) hit = 1'b0;
          end
        end
        if (hit && !overlap_en) m_hist.delete();
      end
      m_match = hit;
      if (cnt_clr)                      m_cnt = hit ? 1 : 0;
      else if (hit && m_cnt < CNT_MAX)  m_cnt++;
      m_primed = en && len_ok(m_len) && (m_hist.size() >= m_len);
    end
  end

  always @(negedge clk) begin
    check("model_match", match, m_match);
    check("model_cnt", match_cnt, m_cnt);
    check("model_primed", primed, m_primed);
  end

  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  logic [6:0]  s1 = 7'b1011011;
  logic [6:0]  e1 = 7'b0001000;
  logic [6:0]  e2 = 7'b0001001;
  logic [9:0]  v3 = 10'b1010110011;
  logic [9:0]  b3 = 10'b1011010110;
  logic [9:0]  e3 = 10'b0000100001;
  logic [9:0]  p3 = 10'b0000111111;
  logic [7:0]  s6 = 8'b10111011;
  logic [2:0]  bad_len [2] = '{3'd0, 3'd5};

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_match", match, 0);
    check("reset_cnt", match_cnt, 0);
    check("reset_primed", primed, 0);
    #9 rst = 1'b0;

    // 1: default pattern, non-overlapping
    en = 1'b1;
    overlap_en = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s1[6-i]);
      check("t1_match", match, e1[6-i]);
    end
    check("t1_cnt", match_cnt, 1);

    // 2: same stream, overlapping
    en = 1'b0;
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    en = 1'b1;
    overlap_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s1[6-i]);
      check("t2_match", match, e2[6-i]);
    end
    check("t2_cnt", match_cnt, 2);

    // 3: 3-bit pattern 110 with valid gaps
    pat_val = 4'b0110;
    pat_len = 3'd3;
    pat_load = 1'b1;
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    check("t3_primed_after_load", primed, 0);
    for (int i = 0; i < 10; i++) begin
      step(v3[9-i], b3[9-i]);
      check("t3_match", match, e3[9-i]);
      check("t3_primed", primed, p3[9-i]);
    end
    check("t3_cnt", match_cnt, 2);

    // 4: single-bit pattern, counter saturation at 3
    pat_val = 4'b0001;
    pat_len = 3'd1;
    pat_load = 1'b1;
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      check("t4_match", match, 1);
      check("t4_cnt", match_cnt, (i < 3) ? i + 1 : 3);
    end
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    check("t4_clr_with_match_cnt", match_cnt, 1);
    check("t4_clr_with_match_pulse", match, 1);
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    check("t4_clr_alone_cnt", match_cnt, 0);

    // 5: async reset mid-pattern, then enable drop mid-pattern
    pat_val = 4'b1011;
    pat_len = 3'd4;
    pat_load = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_match", match, 0);
    check("t5_rst_primed", primed, 0);
    #10 rst = 1'b0;
    step(1'b1, 1'b1);
    check("t5_after_rst_match", match, 0);
    check("t5_after_rst_primed", primed, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    en = 1'b0;
    step(1'b1, 1'b1);
    en = 1'b1;
    step(1'b1, 1'b1);
    check("t5_en_drop_match", match, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("t5_fresh_match", match, 1);

    // 6: invalid lengths never match; load discards the coincident bit
    overlap_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pat_val = 4'b1011;
      pat_len = bad_len[k];
      pat_load = 1'b1;
      step(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        step(1'b1, s6[7-i]);
        check("t6_badlen_match", match, 0);
        check("t6_badlen_primed", primed, 0);
      end
    end
    pat_val = 4'b0011;
    pat_len = 3'd2;
    pat_load = 1'b1;
    step(1'b1, 1'b1);
    check("t6_load_bit_primed", primed, 0);
    step(1'b1, 1'b1);
    check("t6_first_bit_match", match, 0);
    check("t6_first_bit_primed", primed, 0);
    step(1'b1, 1'b1);
    check("t6_second_bit_match", match, 1);
    check("t6_second_bit_primed", primed, 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
